rc5_tx_scheduler: RTL



---
 rtl/rc5_pkg.sv | 48 ++++
 rtl/rc5_key_arb.sv | 37 +++
 rtl/rc5_tx_scheduler.sv | 100 ++++++++++
 3 files changed

// File: rtl/rc5_pkg.sv
// rc5_pkg: shared types, per-key command table and frame builder for the RC-5 transmit path.
// Latency: none; everything here is combinational helpers and constants.
// Backpressure: none.
// Build option: define RC5_EXTENDED_EN for 7-bit RC-5X commands (S2 carries ~cmd[6]).
package rc5_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  localparam int RC5_FRAME_W = 14;

`ifdef RC5_EXTENDED_EN
  localparam int RC5_CMD_W = 7;
`else
  localparam int RC5_CMD_W = 6;
`endif

  // Key index -> command code. Entries beyond the populated keys are never selected.
  function automatic logic [RC5_CMD_W-1:0] key_cmd(input logic [2:0] idx);
    logic [RC5_CMD_W-1:0] cmd;
    case (idx)
      3'd0:    cmd = RC5_CMD_W'(7'h07);
      3'd1:    cmd = RC5_CMD_W'(7'h07);
      3'd2:    cmd = RC5_CMD_W'(7'h04);
      3'd3:    cmd = RC5_CMD_W'(7'h00);
      3'd4:    cmd = RC5_CMD_W'(7'h3F);
      default: cmd = '0;
    endcase
    return cmd;
  endfunction

  // Frame layout, MSB first: {S1, S2, T, A[4:0], C[5:0]}.
  function automatic logic [RC5_FRAME_W-1:0] build_frame(input logic                 t,
                                                         input logic [4:0]           addr,
                                                         input logic [RC5_CMD_W-1:0] cmd);
`ifdef RC5_EXTENDED_EN
    return {1'b1, ~cmd[6], t, addr, cmd[5:0]};
`else
    return {1'b1, 1'b1, t, addr, cmd};
`endif
  endfunction

endpackage

// File: rtl/rc5_key_arb.sv
// rc5_key_arb: rising-edge detect on debounced keys plus lowest-index priority pick.
// Latency: press/press_idx are combinational from key_lvl against a 1-cycle registered copy.
// Backpressure: none; a press not consumed by the caller is simply lost.
// Ports: clock, reset_n (sync, active-low), key_lvl in; press (any rising edge), press_idx out.
module rc5_key_arb #(
  parameter int NUM_KEYS = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_lvl,
  output logic                press,
  output logic [2:0]          press_idx
);

  logic [NUM_KEYS-1:0] key_prev;
  logic [NUM_KEYS-1:0] rise;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      key_prev <= '0;
    end else begin
      key_prev <= key_lvl;
    end
  end

  assign rise  = key_lvl & ~key_prev;
  assign press = |rise;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    press_idx = 3'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rise[i]) press_idx = 3'(i);
    end
  end

endmodule

// File: rtl/rc5_tx_scheduler.sv
// rc5_tx_scheduler: turns key presses into RC-5 frames, repeating every REPEAT_PERIOD cycles while held.
// Latency: tx_start two cycles after the key edge when the encoder is idle; repeats exactly REPEAT_PERIOD apart.
// Backpressure: tx_busy high holds the launch; frames in flight always complete before release is honoured.
// Ports: clock, reset_n (sync, active-low), key_lvl, tx_busy in; tx_start, tx_frame, active_key, active, toggle out.
// Build option: RC5_EXTENDED_EN (see rc5_pkg) selects 7-bit commands; ports are unchanged.
module rc5_tx_scheduler
  import rc5_pkg::*;
#(
  parameter int         NUM_KEYS      = 5,
  parameter int         REPEAT_PERIOD = 11400000,
  parameter logic [4:0] RC5_ADDR      = 5'b00000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_KEYS-1:0]    key_lvl,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [RC5_FRAME_W-1:0] tx_frame,
  output logic [2:0]             active_key,
  output logic                   active,
  output logic                   toggle
);

  localparam int              CNT_W    = $clog2(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REPEAT_PERIOD - 1);
  // GAP hands over to LAUNCH on the edge where the counter arrives at its
  // maximum, so the following tx_start lands exactly REPEAT_PERIOD after the last.
  localparam logic [CNT_W-1:0] CNT_EXIT = CNT_W'(REPEAT_PERIOD - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic [2:0]       press_idx;
  logic [7:0]       keys_wide;
  logic             owner_held;

  rc5_key_arb #(
    .NUM_KEYS (NUM_KEYS)
  ) u_key_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .key_lvl   (key_lvl),
    .press     (press),
    .press_idx (press_idx)
  );

  assign keys_wide  = 8'(key_lvl);
  assign owner_held = keys_wide[active_key];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      tx_start   <= 1'b0;
      tx_frame   <= '0;
      active_key <= 3'd0;
      active     <= 1'b0;
      toggle     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;

      case (state)
        IDLE: begin
          if (press) begin
            active_key <= press_idx;
            toggle     <= ~toggle;
            active     <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_frame <= build_frame(toggle, RC5_ADDR, key_cmd(active_key));
            cnt      <= '0;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= GAP;
        end
        GAP: begin
          // Release wins over the period: drop ownership without waiting.
          if (!owner_held) begin
            active <= 1'b0;
            state  <= IDLE;
          end else if (cnt >= CNT_EXIT) begin
            state <= LAUNCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
